// File: rtl/rv_iopmp_pkg.sv
// Shared IOPMP types: access encoding, error-type codes and the error record.
package rv_iopmp_pkg;

  // Access type as seen by the decision logic (one bit per permission).
  typedef struct packed {
    logic x;
    logic w;
    logic r;
  } access_t;

  // Error-type codes reported by the decision logic.
  localparam logic [2:0] ERR_ILLEGAL_READ  = 3'h1;
  localparam logic [2:0] ERR_ILLEGAL_WRITE = 3'h2;
  localparam logic [2:0] ERR_ILLEGAL_EXEC  = 3'h3;
  localparam logic [2:0] ERR_NOT_HIT       = 3'h5;
  localparam logic [2:0] ERR_UNKNOWN       = 3'h7;

  // Record fields are sized for the platform address/SID widths; ports of the
  // scheduler must not exceed them.
  localparam int unsigned ERR_REC_ADDR_W = 64;
  localparam int unsigned ERR_REC_SID_W  = 8;

  typedef struct packed {
    logic [2:0]                err_type;
    logic [15:0]               index;
    logic [ERR_REC_SID_W-1:0]  sid;
    logic [ERR_REC_ADDR_W-1:0] addr;
    access_t                   access;
  } err_record_t;

endpackage

// File: rtl/rv_iopmp_rr_arb.sv
// Combinational round-robin arbiter: first valid request after ptr wins.
module rv_iopmp_rr_arb #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       en,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic             found;
  logic [IDX_W-1:0] k;

  // Scan ptr+1 .. ptr+NUM_REQ modulo NUM_REQ; the last slot is ptr itself.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      k = IDX_W'((32'(ptr) + off) % NUM_REQ);
      if (en && !found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/rv_iopmp_dl_sched.sv
// Round-robin scheduler sharing one decision-logic instance among requesters.
// Stage A holds the granted request and drives chk_*; stage B holds the
// verdict with valid/ready backpressure. A sticky first-error record is kept.
module rv_iopmp_dl_sched
  import rv_iopmp_pkg::*;
#(
  parameter int unsigned NUM_REQ       = 2,
  parameter int unsigned ADDR_WIDTH    = 64,
  parameter int unsigned SID_WIDTH     = 8,
  parameter int unsigned ERR_CNT_WIDTH = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          enable_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*3-1:0]          req_access_i,
  input  logic [NUM_REQ*SID_WIDTH-1:0]  req_sid_i,
  output logic                          chk_enable_o,
  output logic [ADDR_WIDTH-1:0]         chk_addr_o,
  output logic [2:0]                    chk_access_o,
  output logic [SID_WIDTH-1:0]          chk_sid_o,
  input  logic                          dl_allow_i,
  input  logic                          dl_err_i,
  input  logic [2:0]                    dl_err_type_i,
  input  logic [15:0]                   dl_err_index_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [$clog2(NUM_REQ)-1:0]    rsp_idx_o,
  output logic                          rsp_allow_o,
  output logic                          err_valid_o,
  output logic [2:0]                    err_type_o,
  output logic [15:0]                   err_index_o,
  output logic [SID_WIDTH-1:0]          err_sid_o,
  output logic [ADDR_WIDTH-1:0]         err_addr_o,
  output logic [2:0]                    err_access_o,
  output logic [ERR_CNT_WIDTH-1:0]      err_lost_cnt_o,
  input  logic                          err_clear_i
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  // Round-robin pointer: index of the last granted requester.
  logic [IDX_W-1:0]      ptr_q;

  // Stage A: issue register.
  logic                  issue_valid_q;
  logic [IDX_W-1:0]      issue_idx_q;
  logic [ADDR_WIDTH-1:0] issue_addr_q;
  access_t               issue_access_q;
  logic [SID_WIDTH-1:0]  issue_sid_q;

  // Stage B: response register.
  logic                  rsp_valid_q;
  logic [IDX_W-1:0]      rsp_idx_q;
  logic                  rsp_allow_q;

  // Error record.
  logic                     err_valid_q;
  err_record_t              err_q;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

  logic                     advance_b;
  logic                     accept_a;
  logic [NUM_REQ-1:0]       arb_gnt;
  logic [IDX_W-1:0]         arb_idx;
  logic                     grant_any;

  logic                     err_valid_base;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_base;
  logic                     new_err;

  assign advance_b = issue_valid_q & (~rsp_valid_q | rsp_ready_i);
  assign accept_a  = ~issue_valid_q | advance_b;

  // Grants are suppressed while reset is asserted so no requester sees a
  // handshake that the reset would then discard.
  rv_iopmp_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req (req_valid_i),
    .en  (accept_a & rst_ni),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign grant_any   = |arb_gnt;
  assign req_ready_o = arb_gnt;

  assign chk_enable_o = enable_i & issue_valid_q;
  assign chk_addr_o   = issue_addr_q;
  assign chk_access_o = issue_access_q;
  assign chk_sid_o    = issue_sid_q;

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_idx_o   = rsp_idx_q;
  assign rsp_allow_o = rsp_allow_q;

  assign err_valid_o    = err_valid_q;
  assign err_type_o     = err_q.err_type;
  assign err_index_o    = err_q.index;
  assign err_sid_o      = err_q.sid[SID_WIDTH-1:0];
  assign err_addr_o     = err_q.addr[ADDR_WIDTH-1:0];
  assign err_access_o   = err_q.access;
  assign err_lost_cnt_o = err_cnt_q;

  // Clear is applied before the new error is considered, so an error in the
  // clearing cycle becomes a fresh first error.
  always_comb begin
    err_valid_base = err_clear_i ? 1'b0 : err_valid_q;
    err_cnt_base   = err_clear_i ? '0   : err_cnt_q;
    new_err        = advance_b & enable_i & dl_err_i;
  end

  // Arbitration pointer and issue register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q          <= IDX_W'(NUM_REQ - 1);
      issue_valid_q  <= 1'b0;
      issue_idx_q    <= '0;
      issue_addr_q   <= '0;
      issue_access_q <= '0;
      issue_sid_q    <= '0;
    end else if (accept_a) begin
      issue_valid_q <= grant_any;
      if (grant_any) begin
        ptr_q          <= arb_idx;
        issue_idx_q    <= arb_idx;
        issue_addr_q   <= req_addr_i[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
        issue_access_q <= access_t'(req_access_i[arb_idx*3 +: 3]);
        issue_sid_q    <= req_sid_i[arb_idx*SID_WIDTH +: SID_WIDTH];
      end
    end
  end

  // Response register: capture the verdict on advance, drop on consume.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_allow_q <= 1'b0;
    end else if (advance_b) begin
      rsp_valid_q <= 1'b1;
      rsp_idx_q   <= issue_idx_q;
      rsp_allow_q <= enable_i ? dl_allow_i : 1'b1;
    end else if (rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
    end
  end

  // Sticky first-error record with saturating lost-error counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_valid_q <= 1'b0;
      err_q       <= '0;
      err_cnt_q   <= '0;
    end else begin
      err_valid_q <= err_valid_base;
      err_cnt_q   <= err_cnt_base;
      if (new_err && !err_valid_base) begin
        err_valid_q     <= 1'b1;
        err_q.err_type  <= dl_err_type_i;
        err_q.index     <= dl_err_index_i;
        err_q.sid       <= ERR_REC_SID_W'(issue_sid_q);
        err_q.addr      <= ERR_REC_ADDR_W'(issue_addr_q);
        err_q.access    <= issue_access_q;
      end else if (new_err && (err_cnt_base != '1)) begin
        err_cnt_q <= err_cnt_base + ERR_CNT_WIDTH'(1);
      end else if (err_clear_i) begin
        err_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rv_iopmp_dl_sched.sv
// Scoreboard bench for rv_iopmp_dl_sched (2 requesters, 2-bit lost counter).
module tb_rv_iopmp_dl_sched;

  localparam int NR = 2;
  localparam int AW = 64;
  localparam int SW = 8;
  localparam int CW = 2;
  localparam int IW = $clog2(NR);

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          enable_i;
  logic [NR-1:0] req_valid_i;
  logic [NR-1:0] req_ready_o;
  logic [NR*AW-1:0] req_addr_i;
  logic [NR*3-1:0]  req_access_i;
  logic [NR*SW-1:0] req_sid_i;
  logic          chk_enable_o;
  logic [AW-1:0] chk_addr_o;
  logic [2:0]    chk_access_o;
  logic [SW-1:0] chk_sid_o;
  logic          dl_allow_i;
  logic          dl_err_i;
  logic [2:0]    dl_err_type_i;
  logic [15:0]   dl_err_index_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [IW-1:0] rsp_idx_o;
  logic          rsp_allow_o;
  logic          err_valid_o;
  logic [2:0]    err_type_o;
  logic [15:0]   err_index_o;
  logic [SW-1:0] err_sid_o;
  logic [AW-1:0] err_addr_o;
  logic [2:0]    err_access_o;
  logic [CW-1:0] err_lost_cnt_o;
  logic          err_clear_i;

  always #5 clk = ~clk;

  // Decision-logic stand-in: addresses with bit 13 set are denied.
  assign dl_allow_i = ~chk_addr_o[13];

  rv_iopmp_dl_sched #(
    .NUM_REQ       (NR),
    .ADDR_WIDTH    (AW),
    .SID_WIDTH     (SW),
    .ERR_CNT_WIDTH (CW)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .enable_i       (enable_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .req_access_i   (req_access_i),
    .req_sid_i      (req_sid_i),
    .chk_enable_o   (chk_enable_o),
    .chk_addr_o     (chk_addr_o),
    .chk_access_o   (chk_access_o),
    .chk_sid_o      (chk_sid_o),
    .dl_allow_i     (dl_allow_i),
    .dl_err_i       (dl_err_i),
    .dl_err_type_i  (dl_err_type_i),
    .dl_err_index_i (dl_err_index_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_idx_o      (rsp_idx_o),
    .rsp_allow_o    (rsp_allow_o),
    .err_valid_o    (err_valid_o),
    .err_type_o     (err_type_o),
    .err_index_o    (err_index_o),
    .err_sid_o      (err_sid_o),
    .err_addr_o     (err_addr_o),
    .err_access_o   (err_access_o),
    .err_lost_cnt_o (err_lost_cnt_o),
    .err_clear_i    (err_clear_i)
  );

  typedef struct packed {
    logic [IW-1:0] idx;
    logic          allow;
  } exp_t;

  exp_t sb_q[$];
  int   gnt_log[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   hs_cnt   = 0;
  int   pop_cnt  = 0;
  logic [AW-1:0] mon_addr;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: push on request handshake, pop and compare on response consume.
  always @(negedge clk) begin
    if (rst_ni) begin
      check_val("ready_onehot", 64'($onehot0(req_ready_o)), 64'd1);
      for (int k = 0; k < NR; k++) begin
        if (req_valid_i[k] && req_ready_o[k]) begin
          exp_t e;
          mon_addr = req_addr_i[k*AW +: AW];
          e.idx    = IW'(k);
          e.allow  = enable_i ? ~mon_addr[13] : 1'b1;
          sb_q.push_back(e);
          gnt_log.push_back(k);
          hs_cnt++;
        end
      end
      if (rsp_valid_o && rsp_ready_i) begin
        if (sb_q.size() == 0) begin
          check_val("rsp_unexpected", 64'(rsp_valid_o), 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_val("rsp_idx", 64'(rsp_idx_o), 64'(e.idx));
          check_val("rsp_allow", 64'(rsp_allow_o), 64'(e.allow));
          pop_cnt++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [AW-1:0] addr, input logic [2:0] acc,
                         input logic [SW-1:0] sid);
    req_addr_i[k*AW +: AW] = addr;
    req_access_i[k*3 +: 3] = acc;
    req_sid_i[k*SW +: SW]  = sid;
  endtask

  task automatic do_reset();
    rst_ni      = 1'b0;
    req_valid_i = '0;
    cyc();
    cyc();
    rst_ni = 1'b1;
    sb_q.delete();
    gnt_log.delete();
  endtask

  // One request from requester k with an empty pipeline; the decision inputs
  // are presented during the cycle the request sits in the issue stage.
  task automatic send_err(input int k, input logic [AW-1:0] addr, input logic [2:0] acc,
                          input logic [SW-1:0] sid, input logic [2:0] etype,
                          input logic [15:0] eidx, input logic err, input logic clr);
    cyc();
    set_req(k, addr, acc, sid);
    req_valid_i[k] = 1'b1;
    cyc();
    req_valid_i    = '0;
    dl_err_i       = err;
    dl_err_type_i  = etype;
    dl_err_index_i = eidx;
    err_clear_i    = clr;
    cyc();
    dl_err_i       = 1'b0;
    dl_err_type_i  = '0;
    dl_err_index_i = '0;
    err_clear_i    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int p0;
    int h0;
    rst_ni         = 1'b0;
    enable_i       = 1'b1;
    req_valid_i    = '0;
    req_addr_i     = '0;
    req_access_i   = '0;
    req_sid_i      = '0;
    dl_err_i       = 1'b0;
    dl_err_type_i  = '0;
    dl_err_index_i = '0;
    rsp_ready_i    = 1'b1;
    err_clear_i    = 1'b0;

    // Reset state
    cyc();
    cyc();
    @(negedge clk);
    check_val("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check_val("rst_req_ready", 64'(req_ready_o), 64'd0);
    check_val("rst_chk_enable", 64'(chk_enable_o), 64'd0);
    check_val("rst_err_valid", 64'(err_valid_o), 64'd0);
    check_val("rst_lost_cnt", 64'(err_lost_cnt_o), 64'd0);
    check_val("rst_err_addr", 64'(err_addr_o), 64'd0);
    cyc();
    rst_ni = 1'b1;

    // 1: single read, latency 2
    set_req(0, 64'h1000, 3'b001, 8'h01);
    req_valid_i = 2'b01;
    @(negedge clk);
    check_val("t1_ready_c0", 64'(req_ready_o), 64'h1);
    cyc();
    req_valid_i = '0;
    @(negedge clk);
    check_val("t1_chk_enable", 64'(chk_enable_o), 64'd1);
    check_val("t1_chk_addr", 64'(chk_addr_o), 64'h1000);
    check_val("t1_chk_access", 64'(chk_access_o), 64'h1);
    check_val("t1_rsp_valid_c1", 64'(rsp_valid_o), 64'd0);
    cyc();
    @(negedge clk);
    check_val("t1_rsp_valid_c2", 64'(rsp_valid_o), 64'd1);
    check_val("t1_err_valid", 64'(err_valid_o), 64'd0);
    cyc();
    cyc();

    // 2: both requesters continuously valid, grants alternate from 0
    do_reset();
    set_req(0, 64'h1000, 3'b001, 8'h01);
    set_req(1, 64'h2000, 3'b010, 8'h02);
    p0 = pop_cnt;
    req_valid_i = 2'b11;
    repeat (6) cyc();
    req_valid_i = '0;
    repeat (3) cyc();
    check_val("t2_grant_count", 64'(gnt_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < gnt_log.size()) check_val("t2_grant_order", 64'(gnt_log[i]), 64'(i % 2));
    end
    check_val("t2_rsp_count", 64'(pop_cnt - p0), 64'd6);
    check_val("t2_sb_empty", 64'(sb_q.size()), 64'd0);

    // 3: backpressure, exactly two accepted while rsp_ready_i low
    h0 = hs_cnt;
    p0 = pop_cnt;
    rsp_ready_i = 1'b0;
    req_valid_i = 2'b11;
    cyc();
    cyc();
    @(negedge clk);
    check_val("t3_ready_c2", 64'(req_ready_o), 64'd0);
    check_val("t3_rsp_valid", 64'(rsp_valid_o), 64'd1);
    if (sb_q.size() > 0) check_val("t3_hold_idx_c2", 64'(rsp_idx_o), 64'(sb_q[0].idx));
    cyc();
    @(negedge clk);
    check_val("t3_ready_c3", 64'(req_ready_o), 64'd0);
    if (sb_q.size() > 0) begin
      check_val("t3_hold_idx_c3", 64'(rsp_idx_o), 64'(sb_q[0].idx));
      check_val("t3_hold_allow_c3", 64'(rsp_allow_o), 64'(sb_q[0].allow));
    end
    cyc();
    check_val("t3_accepted", 64'(hs_cnt - h0), 64'd2);
    rsp_ready_i = 1'b1;
    req_valid_i = '0;
    repeat (4) cyc();
    check_val("t3_rsp_count", 64'(pop_cnt - p0), 64'd2);
    check_val("t3_sb_empty", 64'(sb_q.size()), 64'd0);

    // 4: first error sticks, later errors counted and saturate
    do_reset();
    send_err(0, 64'h2000, 3'b010, 8'h12, 3'h2, 16'd5, 1'b1, 1'b0);
    send_err(0, 64'h3000, 3'b001, 8'h34, 3'h5, 16'd9, 1'b1, 1'b0);
    @(negedge clk);
    check_val("t4_err_valid", 64'(err_valid_o), 64'd1);
    check_val("t4_err_type", 64'(err_type_o), 64'h2);
    check_val("t4_err_index", 64'(err_index_o), 64'd5);
    check_val("t4_err_sid", 64'(err_sid_o), 64'h12);
    check_val("t4_err_addr", 64'(err_addr_o), 64'h2000);
    check_val("t4_err_access", 64'(err_access_o), 64'h2);
    check_val("t4_lost_1", 64'(err_lost_cnt_o), 64'd1);
    repeat (5) send_err(0, 64'h1000, 3'b001, 8'h40, 3'h1, 16'd3, 1'b1, 1'b0);
    @(negedge clk);
    check_val("t4_lost_sat", 64'(err_lost_cnt_o), 64'd3);
    check_val("t4_err_type_kept", 64'(err_type_o), 64'h2);

    // 5: clear coincident with a new error records it fresh
    send_err(0, 64'h4000, 3'b100, 8'h56, 3'h3, 16'd7, 1'b1, 1'b1);
    @(negedge clk);
    check_val("t5_err_valid", 64'(err_valid_o), 64'd1);
    check_val("t5_err_type", 64'(err_type_o), 64'h3);
    check_val("t5_err_index", 64'(err_index_o), 64'd7);
    check_val("t5_err_sid", 64'(err_sid_o), 64'h56);
    check_val("t5_lost_0", 64'(err_lost_cnt_o), 64'd0);
    cyc();
    err_clear_i = 1'b1;
    cyc();
    err_clear_i = 1'b0;
    @(negedge clk);
    check_val("t5_clr_valid", 64'(err_valid_o), 64'd0);
    check_val("t5_clr_lost", 64'(err_lost_cnt_o), 64'd0);

    // 6a: disabled IOPMP passes everything and records nothing
    enable_i = 1'b0;
    send_err(0, 64'h2000, 3'b001, 8'h09, 3'h1, 16'd2, 1'b1, 1'b0);
    @(negedge clk);
    check_val("t6_no_err", 64'(err_valid_o), 64'd0);
    enable_i = 1'b1;

    // 6b: reset with both stages full
    cyc();
    rsp_ready_i = 1'b0;
    req_valid_i = 2'b11;
    cyc();
    cyc();
    @(negedge clk);
    check_val("t6_full_rsp", 64'(rsp_valid_o), 64'd1);
    check_val("t6_full_chk", 64'(chk_enable_o), 64'd1);
    cyc();
    rst_ni = 1'b0;
    sb_q.delete();
    cyc();
    rst_ni = 1'b1;
    @(negedge clk);
    check_val("t6_rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check_val("t6_rst_ready", 64'(req_ready_o), 64'h1);
    check_val("t6_rst_chk_enable", 64'(chk_enable_o), 64'd0);
    cyc();
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    repeat (3) cyc();
    check_val("t6_sb_empty", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
